// File: rtl/mem_arbiter_if.sv
// Channel-side and memory-side buses of mem_arbiter.
// slave = arbiter view, master = view of the channels plus the memory.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CH     = 4
);
  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
  logic [NUM_CH-1:0]            ch_req_op;
  logic [NUM_CH-1:0]            ch_rw;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_write;
  logic [NUM_CH-1:0]            ch_req_data;
  logic [DATA_WIDTH-1:0]        ch_read;
  logic [NUM_CH-1:0]            ch_read_valid;
  logic [NUM_CH-1:0]            ch_last;
  logic [NUM_CH-1:0]            ch_err;
  logic                         grant_valid;
  logic [2:0]                   grant_id;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic                         mem_req_op;
  logic                         mem_rw;
  logic [DATA_WIDTH-1:0]        mem_write;
  logic                         mem_write_req_input;
  logic [DATA_WIDTH-1:0]        mem_read;
  logic                         mem_read_valid;
  logic                         mem_last;

  modport slave (
    input  ch_addr, ch_req_op, ch_rw, ch_write,
    input  mem_write_req_input, mem_read, mem_read_valid, mem_last,
    output ch_req_data, ch_read, ch_read_valid, ch_last, ch_err,
    output grant_valid, grant_id, mem_addr, mem_req_op, mem_rw, mem_write
  );

  modport master (
    output ch_addr, ch_req_op, ch_rw, ch_write,
    output mem_write_req_input, mem_read, mem_read_valid, mem_last,
    input  ch_req_data, ch_read, ch_read_valid, ch_last, ch_err,
    input  grant_valid, grant_id, mem_addr, mem_req_op, mem_rw, mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel burst arbiter onto one memory port, with an idle watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [15:0] wd_q, wd_d;
  logic [2:0]  winner;
  logic        any_req;
  logic        activity;
  logic        timeout;
  logic        granted;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0]  last_q, last_d;
  int          idx;

  // Walk from farthest to nearest so the channel right after last_q wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (bus.ch_req_op[idx]) winner = 3'(idx);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bus.ch_req_op[k]) winner = 3'(k);
    end
  end
`endif

  assign any_req  = |bus.ch_req_op;
  assign granted  = (state_q == GRANT);
  assign activity = bus.mem_read_valid | bus.mem_write_req_input | bus.mem_last;
  // The abort fires on the quiet cycle that would make the count reach TIMEOUT.
  assign timeout  = granted && !activity && (wd_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wd_d    = wd_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = winner;
          wd_d    = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = winner;
`endif
        end
      end
      GRANT: begin
        wd_d = activity ? 16'd0 : wd_q + 16'd1;
        if (bus.mem_last || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      wd_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= 3'(NUM_CH - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Memory side is a pure mux of the owning channel while granted.
  always_comb begin
    bus.mem_req_op = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_rw     = 1'b0;
    bus.mem_write  = '0;
    bus.ch_read    = '0;
    if (granted) begin
      bus.mem_req_op = 1'b1;
      bus.mem_addr   = bus.ch_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
      bus.mem_rw     = bus.ch_rw[grant_q];
      bus.mem_write  = bus.ch_write[grant_q*DATA_WIDTH +: DATA_WIDTH];
      bus.ch_read    = bus.mem_read;
    end
  end

  logic [NUM_CH-1:0] sel_w;
  logic [NUM_CH-1:0] rv_w, rd_w, last_w, err_w;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign sel_w[gi]  = granted && (grant_q == 3'(gi));
    assign rv_w[gi]   = sel_w[gi] && bus.mem_read_valid;
    assign rd_w[gi]   = sel_w[gi] && bus.mem_write_req_input;
    assign last_w[gi] = sel_w[gi] && bus.mem_last;
    assign err_w[gi]  = sel_w[gi] && timeout;
  end

  assign bus.ch_read_valid = rv_w;
  assign bus.ch_req_data   = rd_w;
  assign bus.ch_last       = last_w;
  assign bus.ch_err        = err_w;
  assign bus.grant_valid   = granted;
  assign bus.grant_id      = grant_q;

endmodule
